// File: rtl/audio_pwm_dac.sv
// audio_pwm_dac: 256-clock fixed-rate PWM speaker driver. One sample is latched
// per period, shifted by volume, optionally muted, and slew-limited into the duty.
module audio_pwm_dac #(
  parameter int unsigned SLEW = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_i,
  input  logic [1:0] volume_i,
  input  logic       mute_i,
  output logic       pwm_o,
  output logic       period_start_o,
  output logic [7:0] duty_o
);

  localparam logic [8:0] SLEW_W = 9'(SLEW);
  localparam logic [7:0] SLEW_B = 8'(SLEW);

  logic [7:0]        r_cnt;
  logic [7:0]        r_duty;
  logic              r_ps;
  logic [7:0]        w_scaled;
  logic [7:0]        w_target;
  logic [7:0]        w_next_duty;
  logic signed [8:0] w_diff;
  logic [8:0]        w_abs;
  logic              w_update;

  assign w_update = (r_cnt == 8'd255);

  // Volume shift, then mute forces the target to silence.
  always_comb begin
    w_scaled = 8'd0;
    w_target = 8'd0;
    case (volume_i)
      2'd3:    w_scaled = sample_i;
      2'd2:    w_scaled = {1'b0, sample_i[7:1]};
      2'd1:    w_scaled = {2'b00, sample_i[7:2]};
      default: w_scaled = 8'd0;
    endcase
    if (mute_i) begin
      w_target = 8'd0;
    end else begin
      w_target = w_scaled;
    end
  end

  // One bounded step toward the target; the step never crosses it, so no wrap.
  always_comb begin
    w_diff      = $signed({1'b0, w_target}) - $signed({1'b0, r_duty});
    w_abs       = 9'd0;
    w_next_duty = r_duty;
    if (w_diff[8]) begin
      w_abs = $unsigned(-w_diff);
    end else begin
      w_abs = $unsigned(w_diff);
    end
    if (w_abs <= SLEW_W) begin
      w_next_duty = w_target;
    end else if (!w_diff[8]) begin
      w_next_duty = r_duty + SLEW_B;
    end else begin
      w_next_duty = r_duty - SLEW_B;
    end
  end

  // Free-running period counter, period-start strobe and duty register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 8'd0;
      r_duty <= 8'd0;
      r_ps   <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
      r_ps  <= w_update;
      if (w_update) begin
        r_duty <= w_next_duty;
      end else begin
        r_duty <= r_duty;
      end
    end
  end

  assign pwm_o          = (r_cnt < r_duty);
  assign period_start_o = r_ps;
  assign duty_o         = r_duty;

endmodule
